// File: rtl/piso_pkg.sv
// Purpose : shared types for the parallel-in/serial-out transmitter (state encoding).
// Latency : n/a (types and constants only).
// Backpressure: n/a. Macro PISO_PARITY_EN adds the PARITY state to the enumeration.
package piso_pkg;

    // Width of the FSM state register; two bits hold IDLE/SHIFT/PARITY.
    localparam int STATE_W = 2;

`ifdef PISO_PARITY_EN
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/piso_if.sv
// Purpose : load handshake plus serial output bundle of piso_tx.
// Latency : n/a (wiring only).
// Backpressure: load_ready from the transmitter qualifies load_valid from the source.
// Ports   : parallel_in/load_valid (source -> tx), load_ready, serial_out, serial_valid,
//           frame_start, done (tx -> sink). master = source/sink side, slave = transmitter.
interface piso_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             done;

    modport master (
        output parallel_in, load_valid,
        input  load_ready, serial_out, serial_valid, frame_start, done
    );

    modport slave (
        input  parallel_in, load_valid,
        output load_ready, serial_out, serial_valid, frame_start, done
    );
endinterface

// File: rtl/piso_tx.sv
// Purpose : serialises a WIDTH-bit frame one bit per cycle, optional even-parity trailer.
// Latency : first bit one cycle after an accepted load; frame lasts WIDTH (+1 with parity) cycles.
// Backpressure: load_ready high in IDLE and on a frame's final cycle, allowing gapless frames.
// Ports   : clk, reset (sync, active-low), bus (piso_if.slave).
// Config  : define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic   clk,
    input  logic   reset,
    piso_if.slave  bus
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sreg;
`ifdef PISO_PARITY_EN
    logic               par;
`endif

    logic               last_cycle;
    logic               accept;

    // Bit that leaves next, given the transmit order.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Drop the bit just sent; the register drains to zero over a frame.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // Final output cycle of a frame: last data bit, or the parity bit when present.
`ifdef PISO_PARITY_EN
    assign last_cycle = (state == PARITY);
`else
    assign last_cycle = (state == SHIFT) && (cnt == LAST);
`endif

    // Ready depends on state/counter only, so the source may wait on it combinationally.
    assign bus.load_ready = (state == IDLE) || last_cycle;
    assign accept         = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            cnt              <= '0;
            sreg             <= '0;
`ifdef PISO_PARITY_EN
            par              <= 1'b0;
`endif
            bus.serial_out   <= 1'b0;
            bus.serial_valid <= 1'b0;
            bus.frame_start  <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            if (accept) begin
                // Capture and present the first bit at once; the register keeps the rest.
                state            <= SHIFT;
                cnt              <= '0;
                sreg             <= advance(bus.parallel_in);
`ifdef PISO_PARITY_EN
                par              <= ^bus.parallel_in;
`endif
                bus.serial_out   <= head(bus.parallel_in);
                bus.serial_valid <= 1'b1;
                bus.frame_start  <= 1'b1;
                bus.done         <= 1'b0;
            end else begin
                case (state)
                    SHIFT: begin
                        if (cnt != LAST) begin
                            cnt            <= cnt + CNT_W'(1);
                            sreg           <= advance(sreg);
                            bus.serial_out <= head(sreg);
                            // Next bit closes the frame only when no parity trailer follows.
                            bus.done       <= !HAS_PARITY && ((cnt + CNT_W'(1)) == LAST);
                        end else begin
`ifdef PISO_PARITY_EN
                            state            <= PARITY;
                            bus.serial_out   <= par;
                            bus.serial_valid <= 1'b1;
                            bus.done         <= 1'b1;
`else
                            state            <= IDLE;
                            cnt              <= '0;
                            sreg             <= '0;
                            bus.serial_out   <= 1'b0;
                            bus.serial_valid <= 1'b0;
                            bus.done         <= 1'b0;
`endif
                        end
                    end
`ifdef PISO_PARITY_EN
                    PARITY: begin
                        state            <= IDLE;
                        cnt              <= '0;
                        sreg             <= '0;
                        bus.serial_out   <= 1'b0;
                        bus.serial_valid <= 1'b0;
                        bus.done         <= 1'b0;
                    end
`endif
                    default: begin
                        state            <= IDLE;
                        cnt              <= '0;
                        sreg             <= '0;
                        bus.serial_out   <= 1'b0;
                        bus.serial_valid <= 1'b0;
                        bus.done         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: number of data bits per frame, minimum 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; the block is held in reset while low at a rising edge.
REQ-005 parallel_in  input  WIDTH  frame data, sampled only on an accepted load.
REQ-006 load_valid  input  1  source requests a load of parallel_in.
REQ-007 load_ready  output  1  block can accept a load this cycle.
REQ-008 serial_out  output  1  current serial bit.
REQ-009 serial_valid  output  1  serial_out carries a frame bit this cycle.
REQ-010 frame_start  output  1  high for the first bit of each frame.
REQ-011 done  output  1  high for the final bit of each frame (the parity bit when parity is enabled).

Function
REQ-012 States SHALL be IDLE, SHIFT and PARITY (PARITY exists only when parity is enabled).
REQ-013 A load SHALL be accepted at a rising edge where load_valid and load_ready are both high; this captures parallel_in and clears the bit counter.
REQ-014 The first bit SHALL appear on serial_out in the cycle after acceptance (latency 1), with serial_valid and frame_start high.
REQ-015 SHIFT SHALL drive one bit per cycle for exactly WIDTH cycles, in the order set by MSB_FIRST.
REQ-016 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL count 0..WIDTH-1 with no wrap inside a frame.
REQ-017 load_ready SHALL be high in IDLE and during the final output cycle of a frame, and low otherwise.
REQ-018 load_ready SHALL be derived from state and counter only, never from load_valid.
REQ-019 A load accepted during the final cycle SHALL start the next frame on the following cycle with no idle gap; frame_start is high for that frame's first bit.
REQ-020 With no pending load after the final cycle, the block SHALL return to IDLE.
REQ-021 In IDLE, serial_out, serial_valid, frame_start and done SHALL all be 0.
REQ-022 load_valid while load_ready is low SHALL be ignored, and changes on parallel_in SHALL NOT affect a frame in flight.
REQ-023 serial_out, serial_valid, frame_start and done SHALL be registered outputs.

Reset
REQ-024 On reset at an edge, the next cycle SHALL show state IDLE, counter 0, shift register 0, serial_out 0, serial_valid 0, frame_start 0, done 0 and load_ready 1.
REQ-025 Reset mid-frame SHALL abort the frame and discard its remaining bits, with no done pulse.
REQ-026 Reset SHALL take priority over a simultaneous load.

Configuration
REQ-027 Macro PISO_PARITY_EN: when defined, one even-parity bit (XOR of the captured data) SHALL follow the data bits in state PARITY, with serial_valid 1.
REQ-028 With PISO_PARITY_EN defined, done and the final-cycle load_ready apply to the parity cycle, so a frame lasts WIDTH+1 cycles.
REQ-029 With PISO_PARITY_EN undefined, the PARITY state and its logic SHALL be absent, and a frame lasts WIDTH cycles.

Structure
REQ-030 Package piso_pkg SHALL hold the state enumeration (IDLE, SHIFT, PARITY) and the state-encoding width constant.
REQ-031 No sub-module: the counter, shift register and parity logic are inline in piso_tx.

Verification (WIDTH=4)
REQ-032 Reset low then high, then load 1010 with MSB_FIRST=1 -> serial_out 1,0,1,0 on cycles 1-4; frame_start on cycle 1; done on cycle 4; IDLE on cycle 5.
REQ-033 Back-to-back: 1001 loaded, then 0010 presented during the final cycle -> serial_out 1,0,0,1,0,0,1,0 with serial_valid continuously high and frame_start on cycles 1 and 5.
REQ-034 Load 1111, then hold reset low after 2 bits -> serial_valid 0 and load_ready 1 on the next cycle; no done pulse.
REQ-035 Load 1010, then present 1100 with load_valid high on cycle 2 -> the 1100 load is ignored and the output remains 1,0,1,0.
REQ-036 MSB_FIRST=0, load 1000 -> serial_out 0,0,0,1.
REQ-037 PISO_PARITY_EN defined: load 1010 -> parity bit 0 on cycle 5; load 1011 -> parity bit 1 on cycle 5; done on cycle 5 in both cases.
